// File: rtl/rob_if.sv
// Reorder-buffer bundle: decoder alloc, EX writeback, RS broadcast and commit/flush toward the regfile and fetch.
// master = decoder/EX/environment side, slave = the ROB itself.
interface rob_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              if_idle;
    logic              alloc_valid;
    logic [TAG_W-1:0]  alloc_tag;
    logic [4:0]        alloc_rd;
    logic [ADDR_W-1:0] alloc_pc;
    logic              alloc_is_branch;
    logic              alloc_pred_taken;
    logic              ex_valid;
    logic [TAG_W-1:0]  ex_tag;
    logic [DATA_W-1:0] ex_data;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic [TAG_W-1:0]  tag_renew;
    logic [DATA_W-1:0] data_renew;
    logic              commit_valid;
    logic [4:0]        commit_rd;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W-1:0]  commit_tag;
    logic              clear;
    logic [ADDR_W-1:0] pc_redirect;

    modport master (
        output rdy, alloc_valid, alloc_rd, alloc_pc, alloc_is_branch, alloc_pred_taken,
               ex_valid, ex_tag, ex_data, ex_taken, ex_target,
        input  if_idle, alloc_tag, tag_renew, data_renew, commit_valid, commit_rd,
               commit_data, commit_tag, clear, pc_redirect
    );

    modport slave (
        input  rdy, alloc_valid, alloc_rd, alloc_pc, alloc_is_branch, alloc_pred_taken,
               ex_valid, ex_tag, ex_data, ex_taken, ex_target,
        output if_idle, alloc_tag, tag_renew, data_renew, commit_valid, commit_rd,
               commit_data, commit_tag, clear, pc_redirect
    );
endinterface

// File: rtl/rob.sv
// Reorder buffer: tags issued instructions, collects out-of-order EX results, broadcasts them one cycle later,
// commits one entry per cycle in program order and flushes everything when a committing branch was mispredicted.
module rob #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32
) (
    input  logic  clk,
    input  logic  rst,
    rob_if.slave  bus
);
    localparam logic [TAG_W-1:0] FIRST = TAG_W'(1);
    localparam logic [TAG_W-1:0] LAST  = TAG_W'(ROB_SIZE - 1);

    // Slot 0 is the empty tag, so pointers cycle through 1..ROB_SIZE-1 only.
    function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
        return (p == LAST) ? FIRST : p + FIRST;
    endfunction

    logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;

    logic [4:0]          rd_q     [ROB_SIZE];
    logic [ADDR_W-1:0]   pc_q     [ROB_SIZE];
    logic                br_q     [ROB_SIZE];
    logic                pred_q   [ROB_SIZE];
    logic [DATA_W-1:0]   data_q   [ROB_SIZE];
    logic                taken_q  [ROB_SIZE];
    logic [ADDR_W-1:0]   target_q [ROB_SIZE];

    logic [TAG_W-1:0]    tag_renew_q, commit_tag_q;
    logic [DATA_W-1:0]   data_renew_q, commit_data_q;
    logic [4:0]          commit_rd_q;
    logic                commit_valid_q, clear_q;
    logic [ADDR_W-1:0]   pc_redirect_q;

    logic                if_idle, alloc_fire, wb_fire, commit_fire, mispredict;
    logic [ADDR_W-1:0]   redirect;

    always_comb begin
        if_idle     = (count_q != LAST);
        alloc_fire  = bus.rdy & bus.alloc_valid & if_idle;
        wb_fire     = bus.rdy & bus.ex_valid & (bus.ex_tag != '0) & busy_q[bus.ex_tag];
        commit_fire = bus.rdy & busy_q[head_q] & ready_q[head_q];
        mispredict  = commit_fire & br_q[head_q] & (taken_q[head_q] != pred_q[head_q]);
        redirect    = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + ADDR_W'(4);

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        if (mispredict) begin
            head_d  = FIRST;
            tail_d  = FIRST;
            count_d = '0;
            busy_d  = '0;
            ready_d = '0;
        end else begin
            if (commit_fire) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = ptr_inc(head_q);
            end
            if (wb_fire) begin
                ready_d[bus.ex_tag] = 1'b1;
            end
            if (alloc_fire) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                tail_d          = ptr_inc(tail_q);
            end
            count_d = count_q + TAG_W'(alloc_fire) - TAG_W'(commit_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q         <= FIRST;
            tail_q         <= FIRST;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            tag_renew_q    <= '0;
            data_renew_q   <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
            commit_tag_q   <= '0;
            clear_q        <= 1'b0;
            pc_redirect_q  <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            commit_valid_q <= commit_fire;
            clear_q        <= mispredict;
            // A flush silences the broadcast so the RS never wakes on a squashed result.
            tag_renew_q    <= (wb_fire && !mispredict) ? bus.ex_tag : '0;
            if (wb_fire && !mispredict) begin
                data_renew_q <= bus.ex_data;
            end
            if (commit_fire) begin
                commit_rd_q   <= rd_q[head_q];
                commit_data_q <= data_q[head_q];
                commit_tag_q  <= head_q;
            end
            if (mispredict) begin
                pc_redirect_q <= redirect;
            end
        end
    end

    // Payload needs no reset: busy/ready alone decide whether a slot is meaningful.
    always_ff @(posedge clk) begin
        if (alloc_fire && !mispredict) begin
            rd_q[tail_q]   <= bus.alloc_rd;
            pc_q[tail_q]   <= bus.alloc_pc;
            br_q[tail_q]   <= bus.alloc_is_branch;
            pred_q[tail_q] <= bus.alloc_pred_taken;
        end
        if (wb_fire && !mispredict) begin
            data_q[bus.ex_tag]   <= bus.ex_data;
            taken_q[bus.ex_tag]  <= bus.ex_taken;
            target_q[bus.ex_tag] <= bus.ex_target;
        end
    end

    assign bus.if_idle      = if_idle;
    assign bus.alloc_tag    = tail_q;
    assign bus.tag_renew    = tag_renew_q;
    assign bus.data_renew   = data_renew_q;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_rd    = commit_rd_q;
    assign bus.commit_data  = commit_data_q;
    assign bus.commit_tag   = commit_tag_q;
    assign bus.clear        = clear_q;
    assign bus.pc_redirect  = pc_redirect_q;
endmodule

// File: tb/tb_rob.sv
// Bench for rob: in-order queue model of in-flight instructions, checked every cycle, plus directed literal checks.
module tb_rob;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_if #(.TAG_W(4), .DATA_W(32), .ADDR_W(32)) rif ();
    rob u_dut (.clk(clk), .rst(rst), .bus(rif));

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        br, pt, done, tk;
        logic [31:0] data, tgt;
    } ent_t;

    ent_t        mq[$];
    logic [3:0]  nt;
    logic [3:0]  x_tagr, x_ctag;
    logic [31:0] x_datar, x_cdata, x_redir;
    logic [4:0]  x_crd;
    logic        x_cv, x_clr;
    bit          chk_en = 0;
    int          checks = 0;
    int          errors = 0;

    logic        rdy_v, a_v, a_br, a_pt, e_v, e_tk;
    logic [4:0]  a_rd;
    logic [31:0] a_pc, e_data, e_tgt;
    logic [3:0]  e_tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        nt = 4'd1;
        x_tagr = '0; x_datar = '0; x_cv = 0; x_crd = '0; x_cdata = '0; x_ctag = '0;
        x_clr = 0; x_redir = '0;
    endtask

    // One clock edge of the ROB seen as a program-ordered list of in-flight instructions.
    task automatic model_step();
        bit idle, com, misp;
        int wi;
        ent_t n;
        if (!rdy_v) begin
            x_cv = 0; x_clr = 0; x_tagr = '0;
            return;
        end
        idle = (mq.size() != 15);
        com  = (mq.size() > 0) && mq[0].done;
        misp = com && mq[0].br && (mq[0].tk != mq[0].pt);
        wi = -1;
        if (e_v && e_tag != 4'd0)
            foreach (mq[i]) if (mq[i].tag == e_tag) wi = i;
        x_cv   = com;
        x_clr  = misp;
        x_tagr = (wi >= 0 && !misp) ? e_tag : 4'd0;
        if (wi >= 0 && !misp) x_datar = e_data;
        if (com) begin
            x_crd = mq[0].rd; x_cdata = mq[0].data; x_ctag = mq[0].tag;
        end
        if (misp) begin
            x_redir = mq[0].tk ? mq[0].tgt : mq[0].pc + 32'd4;
            mq.delete();
            nt = 4'd1;
        end else begin
            if (wi >= 0) begin
                mq[wi].done = 1; mq[wi].data = e_data; mq[wi].tk = e_tk; mq[wi].tgt = e_tgt;
            end
            if (com) void'(mq.pop_front());
            if (a_v && idle) begin
                n.tag = nt; n.rd = a_rd; n.pc = a_pc; n.br = a_br; n.pt = a_pt;
                n.done = 0; n.tk = 0; n.data = '0; n.tgt = '0;
                mq.push_back(n);
                nt = (nt == 4'd15) ? 4'd1 : nt + 4'd1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("tag_renew", 32'(rif.tag_renew), 32'(x_tagr));
            chk("commit_valid", 32'(rif.commit_valid), 32'(x_cv));
            chk("clear", 32'(rif.clear), 32'(x_clr));
            chk("alloc_tag", 32'(rif.alloc_tag), 32'(nt));
            chk("if_idle", 32'(rif.if_idle), 32'(mq.size() != 15));
            if (x_tagr != 4'd0) chk("data_renew", rif.data_renew, x_datar);
            if (x_cv) begin
                chk("commit_rd", 32'(rif.commit_rd), 32'(x_crd));
                chk("commit_data", rif.commit_data, x_cdata);
                chk("commit_tag", 32'(rif.commit_tag), 32'(x_ctag));
            end
            if (x_clr) chk("pc_redirect", rif.pc_redirect, x_redir);
        end
    end

    task automatic nop();
        rdy_v = 1; a_v = 0; a_rd = '0; a_pc = '0; a_br = 0; a_pt = 0;
        e_v = 0; e_tag = '0; e_data = '0; e_tk = 0; e_tgt = '0;
    endtask

    // Present inputs for the coming edge, advance the model, return at the next falling edge.
    task automatic cyc();
        rif.rdy = rdy_v; rif.alloc_valid = a_v; rif.alloc_rd = a_rd; rif.alloc_pc = a_pc;
        rif.alloc_is_branch = a_br; rif.alloc_pred_taken = a_pt;
        rif.ex_valid = e_v; rif.ex_tag = e_tag; rif.ex_data = e_data;
        rif.ex_taken = e_tk; rif.ex_target = e_tgt;
        model_step();
        @(negedge clk);
        nop();
    endtask

    task automatic set_alloc(input logic [4:0] rd, input logic [31:0] pc, input logic br, input logic pt);
        a_v = 1; a_rd = rd; a_pc = pc; a_br = br; a_pt = pt;
    endtask

    task automatic set_wb(input logic [3:0] t, input logic [31:0] d, input logic tk, input logic [31:0] tg);
        e_v = 1; e_tag = t; e_data = d; e_tk = tk; e_tgt = tg;
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        nop();
        cyc_inputs_init: begin
            rif.rdy = 1; rif.alloc_valid = 0; rif.alloc_rd = '0; rif.alloc_pc = '0;
            rif.alloc_is_branch = 0; rif.alloc_pred_taken = 0; rif.ex_valid = 0;
            rif.ex_tag = '0; rif.ex_data = '0; rif.ex_taken = 0; rif.ex_target = '0;
        end
        model_reset();
        chk_en = 1;
        do_reset();

        // Reset state
        chk("rst_alloc_tag", 32'(rif.alloc_tag), 32'd1);
        chk("rst_if_idle", 32'(rif.if_idle), 32'd1);
        chk("rst_tag_renew", 32'(rif.tag_renew), 32'd0);
        chk("rst_commit_valid", 32'(rif.commit_valid), 32'd0);
        chk("rst_clear", 32'(rif.clear), 32'd0);

        // Fill to 15, then one rejected alloc
        for (int i = 0; i < 16; i++) begin
            set_alloc(5'(i), 32'(i * 4), 0, 0);
            cyc();
            chk("fill_alloc_tag", 32'(rif.alloc_tag), (i < 14) ? 32'(i + 2) : 32'd1);
            chk("fill_if_idle", 32'(rif.if_idle), (i < 14) ? 32'd1 : 32'd0);
        end

        // Out-of-order writeback, in-order commit
        do_reset();
        for (int i = 0; i < 3; i++) begin set_alloc(5'(i + 1), 32'(i * 4), 0, 0); cyc(); end
        set_wb(4'd3, 32'h33, 0, 0); cyc();
        chk("ooo_renew3_tag", 32'(rif.tag_renew), 32'd3);
        chk("ooo_renew3_data", rif.data_renew, 32'h33);
        set_wb(4'd1, 32'h11, 0, 0); cyc();
        chk("ooo_renew1_tag", 32'(rif.tag_renew), 32'd1);
        chk("ooo_renew1_data", rif.data_renew, 32'h11);
        cyc();
        chk("ooo_commit1_valid", 32'(rif.commit_valid), 32'd1);
        chk("ooo_commit1_tag", 32'(rif.commit_tag), 32'd1);
        chk("ooo_commit1_data", rif.commit_data, 32'h11);
        set_wb(4'd2, 32'h22, 0, 0); cyc();
        chk("ooo_wait3", 32'(rif.commit_valid), 32'd0);
        cyc();
        chk("ooo_commit2_tag", 32'(rif.commit_tag), 32'd2);
        chk("ooo_commit2_data", rif.commit_data, 32'h22);
        cyc();
        chk("ooo_commit3_valid", 32'(rif.commit_valid), 32'd1);
        chk("ooo_commit3_tag", 32'(rif.commit_tag), 32'd3);
        chk("ooo_commit3_data", rif.commit_data, 32'h33);

        // Steady stream: the 16th allocation reuses tag 1
        do_reset();
        for (int i = 0; i < 40; i++) begin
            chk("stream_tag", 32'(rif.alloc_tag), 32'((i % 15) + 1));
            set_alloc(5'(i), 32'(i * 4), 0, 0);
            if (i > 0) set_wb(4'(((i - 1) % 15) + 1), 32'(i), 0, 0);
            cyc();
        end

        // Mispredict: predicted not-taken, actually taken
        do_reset();
        set_alloc(5'd1, 32'h100, 1, 0); cyc();
        for (int i = 0; i < 2; i++) begin set_alloc(5'(i + 2), 32'h104 + 32'(i * 4), 0, 0); cyc(); end
        set_alloc(5'd4, 32'h10c, 0, 0); set_wb(4'd1, 32'hB1, 1, 32'h200); cyc();
        set_alloc(5'd5, 32'h110, 0, 0); set_wb(4'd2, 32'hB2, 0, 0); cyc();
        chk("mp1_clear", 32'(rif.clear), 32'd1);
        chk("mp1_redirect", rif.pc_redirect, 32'h200);
        chk("mp1_alloc_tag", 32'(rif.alloc_tag), 32'd1);
        chk("mp1_if_idle", 32'(rif.if_idle), 32'd1);
        chk("mp1_renew_forced", 32'(rif.tag_renew), 32'd0);
        chk("mp1_commit_tag", 32'(rif.commit_tag), 32'd1);
        cyc();
        chk("mp1_clear_pulse", 32'(rif.clear), 32'd0);
        // Predicted taken, actually not taken
        set_alloc(5'd6, 32'h100, 1, 1); cyc();
        set_wb(4'd1, 32'hC1, 0, 32'h300); cyc();
        cyc();
        chk("mp2_clear", 32'(rif.clear), 32'd1);
        chk("mp2_redirect", rif.pc_redirect, 32'h104);

        // Async reset with live entries and active pulses
        do_reset();
        for (int i = 0; i < 5; i++) begin set_alloc(5'(i + 1), 32'(i * 4), 0, 0); cyc(); end
        set_wb(4'd1, 32'hA1, 0, 0); cyc();
        set_wb(4'd2, 32'hA2, 0, 0); cyc();
        chk("ar_pre_commit", 32'(rif.commit_valid), 32'd1);
        #2 rst = 1;
        model_reset();
        #1;
        chk("ar_tag_renew", 32'(rif.tag_renew), 32'd0);
        chk("ar_commit_valid", 32'(rif.commit_valid), 32'd0);
        chk("ar_alloc_tag", 32'(rif.alloc_tag), 32'd1);
        chk("ar_if_idle", 32'(rif.if_idle), 32'd1);
        @(negedge clk);
        rst = 0;

        // Full and committing on the same edge: alloc rejected
        do_reset();
        for (int i = 0; i < 15; i++) begin set_alloc(5'(i), 32'(i * 4), 0, 0); cyc(); end
        set_wb(4'd1, 32'hF1, 0, 0); cyc();
        set_alloc(5'd20, 32'h500, 0, 0); cyc();
        chk("ff_commit", 32'(rif.commit_valid), 32'd1);
        chk("ff_if_idle", 32'(rif.if_idle), 32'd1);
        chk("ff_alloc_tag", 32'(rif.alloc_tag), 32'd1);
        set_alloc(5'd21, 32'h504, 0, 0); cyc();
        chk("ff_refull", 32'(rif.if_idle), 32'd0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int idx[$];
            int k;
            rdy_v = ($urandom_range(9) != 0);
            if ($urandom_range(9) < 6) set_alloc(5'($urandom), $urandom & 32'hFFFF_FFFC,
                                                 ($urandom_range(4) == 0), 1'($urandom));
            foreach (mq[i]) if (!mq[i].done) idx.push_back(i);
            if (idx.size() > 0 && $urandom_range(1) == 0) begin
                k = ($urandom_range(1) == 0) ? idx[0] : idx[$urandom_range(idx.size() - 1)];
                set_wb(mq[k].tag, $urandom, ($urandom_range(3) == 0) ? !mq[k].pt : mq[k].pt, $urandom);
            end else if ($urandom_range(9) == 0) begin
                set_wb(4'($urandom), $urandom, 1'($urandom), $urandom);
                foreach (mq[i]) if (mq[i].tag == e_tag && mq[i].done) e_v = 0;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
